// File: rtl/uart_host_cmd_master.sv
// Host-side UART command initiator: serializes one command request into
// protocol bytes, then gathers the response bytes (or times out).
module uart_host_cmd_master #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_WIDTH    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_TYPE,
  input  logic [7:0]  CMD_ADDR,
  input  logic [7:0]  CMD_DATA,
  input  logic [3:0]  CMD_FUN,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [15:0] RSP_DATA,
  output logic        RSP_VALID,
  output logic        RSP_TIMEOUT,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
  typedef enum logic [1:0] {RF_WR = 2'd0, RF_RD = 2'd1, ALU_OP = 2'd2, ALU_NOP = 2'd3} cmd_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYC - 1);

  state_t              state;
  cmd_t                type_q;
  logic [7:0]          addr_q;
  logic [7:0]          data_q;
  logic [3:0]          fun_q;
  logic [1:0]          idx;
  logic                rsp_cnt;
  logic [TO_WIDTH-1:0] to_cnt;

  // Protocol byte at position idx of the frame for a given command type.
  function automatic logic [7:0] frame_byte(input cmd_t typ, input logic [1:0] i,
                                            input logic [7:0] a, input logic [7:0] d,
                                            input logic [3:0] f);
    frame_byte = '0;
    case (typ)
      RF_WR:   frame_byte = (i == 2'd0) ? 8'hAA : (i == 2'd1) ? a : d;
      RF_RD:   frame_byte = (i == 2'd0) ? 8'hBB : a;
      ALU_OP:  frame_byte = (i == 2'd0) ? 8'hCC : (i == 2'd1) ? a :
                            (i == 2'd2) ? d : {4'b0, f};
      ALU_NOP: frame_byte = (i == 2'd0) ? 8'hDD : {4'b0, f};
      default: frame_byte = '0;
    endcase
  endfunction

  // Index of the final byte of each frame.
  function automatic logic [1:0] last_idx(input cmd_t typ);
    case (typ)
      RF_WR:   last_idx = 2'd2;
      ALU_OP:  last_idx = 2'd3;
      default: last_idx = 2'd1;
    endcase
  endfunction

  assign CMD_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);

  // Command FSM with registered TX and response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      type_q      <= RF_WR;
      addr_q      <= '0;
      data_q      <= '0;
      fun_q       <= '0;
      idx         <= '0;
      rsp_cnt     <= 1'b0;
      to_cnt      <= '0;
      TX_DATA     <= '0;
      TX_VALID    <= 1'b0;
      RSP_DATA    <= '0;
      RSP_VALID   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      RSP_VALID   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            type_q   <= cmd_t'(CMD_TYPE);
            addr_q   <= CMD_ADDR;
            data_q   <= CMD_DATA;
            fun_q    <= CMD_FUN;
            idx      <= '0;
            rsp_cnt  <= 1'b0;
            to_cnt   <= '0;
            RSP_DATA <= '0;
            // First byte is presented straight from the request so it is valid next cycle.
            TX_DATA  <= frame_byte(cmd_t'(CMD_TYPE), 2'd0, CMD_ADDR, CMD_DATA, CMD_FUN);
            TX_VALID <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (TX_READY) begin
            if (idx == last_idx(type_q)) begin
              TX_VALID <= 1'b0;
              if (type_q == RF_WR) begin
                state     <= DONE;
                RSP_VALID <= 1'b1;
              end else begin
                state <= WAIT_RSP;
              end
            end else begin
              idx     <= idx + 2'd1;
              TX_DATA <= frame_byte(type_q, idx + 2'd1, addr_q, data_q, fun_q);
            end
          end
        end
        WAIT_RSP: begin
          // A received byte takes priority over an expiring timeout.
          if (RX_VALID) begin
            to_cnt <= '0;
            if (!rsp_cnt) RSP_DATA[7:0]  <= RX_DATA;
            else          RSP_DATA[15:8] <= RX_DATA;
            if (type_q == RF_RD || rsp_cnt) begin
              state     <= DONE;
              RSP_VALID <= 1'b1;
            end else begin
              rsp_cnt <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state       <= IDLE;
            RSP_TIMEOUT <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_cmd_master.sv
// Directed bench for uart_host_cmd_master with hand-computed expectations.
module tb_uart_host_cmd_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_TYPE = '0;
  logic [7:0]  CMD_ADDR = '0;
  logic [7:0]  CMD_DATA = '0;
  logic [3:0]  CMD_FUN = '0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID;
  logic        RSP_TIMEOUT;
  logic        BUSY;

  int vectors = 0;
  int miscompares = 0;

  uart_host_cmd_master #(.TIMEOUT_CYC(16), .TO_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_FUN(CMD_FUN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    step;
    vectors++; if (CMD_READY !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", CMD_READY); end
    vectors++; if (TX_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_txv got %b exp 0", TX_VALID); end
    vectors++; if (TX_DATA !== 8'h00) begin miscompares++; $display("FAIL rst_txd got %h exp 00", TX_DATA); end
    vectors++; if (RSP_DATA !== 16'h0000) begin miscompares++; $display("FAIL rst_rsp got %h exp 0000", RSP_DATA); end
    vectors++; if ({RSP_VALID, RSP_TIMEOUT, BUSY} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b exp 000", {RSP_VALID, RSP_TIMEOUT, BUSY}); end
    RST = 1'b0;
    step;
  endtask

  task automatic test_rf_rd;
    logic [7:0] exp [2];
    exp = '{8'hBB, 8'h02};
    CMD_TYPE = 2'd1; CMD_ADDR = 8'h02; CMD_DATA = 8'h00; CMD_FUN = 4'h0; TX_READY = 1'b1;
    CMD_VALID = 1'b1;
    step;
    CMD_VALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin miscompares++; $display("FAIL rd_tx%0d got %b/%h exp 1/%h", i, TX_VALID, TX_DATA, exp[i]); end
      step;
    end
    vectors++; if (TX_VALID !== 1'b0 || BUSY !== 1'b1) begin miscompares++; $display("FAIL rd_wait got txv=%b busy=%b exp 0/1", TX_VALID, BUSY); end
    step;
    step;
    vectors++; if (RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL rd_early got %b exp 0", RSP_VALID); end
    RX_VALID = 1'b1; RX_DATA = 8'h81;
    step;
    RX_VALID = 1'b0;
    vectors++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0081) begin miscompares++; $display("FAIL rd_rsp got %b/%h exp 1/0081", RSP_VALID, RSP_DATA); end
    step;
    vectors++; if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b0 || RSP_DATA !== 16'h0081) begin miscompares++; $display("FAIL rd_idle got rdy=%b v=%b d=%h exp 1/0/0081", CMD_READY, RSP_VALID, RSP_DATA); end
  endtask

  task automatic test_rf_wr;
    logic [7:0] exp [3];
    exp = '{8'hAA, 8'h05, 8'h3C};
    CMD_TYPE = 2'd0; CMD_ADDR = 8'h05; CMD_DATA = 8'h3C; CMD_FUN = 4'h0; TX_READY = 1'b1;
    CMD_VALID = 1'b1;
    vectors++; if (CMD_READY !== 1'b1) begin miscompares++; $display("FAIL wr_ready got %b exp 1", CMD_READY); end
    step;
    CMD_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin miscompares++; $display("FAIL wr_tx%0d got %b/%h exp 1/%h", i, TX_VALID, TX_DATA, exp[i]); end
      step;
    end
    vectors++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0000) begin miscompares++; $display("FAIL wr_rsp got %b/%h exp 1/0000", RSP_VALID, RSP_DATA); end
    vectors++; if (TX_VALID !== 1'b0 || CMD_READY !== 1'b0) begin miscompares++; $display("FAIL wr_done got txv=%b rdy=%b exp 0/0", TX_VALID, CMD_READY); end
    step;
    vectors++; if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL wr_idle got rdy=%b v=%b exp 1/0", CMD_READY, RSP_VALID); end
  endtask

  task automatic test_alu_op;
    logic [7:0] exp [4];
    exp = '{8'hCC, 8'h0A, 8'h14, 8'h00};
    CMD_TYPE = 2'd2; CMD_ADDR = 8'h0A; CMD_DATA = 8'h14; CMD_FUN = 4'h0;
    CMD_VALID = 1'b1;
    step;
    CMD_VALID = 1'b0;
    CMD_ADDR = 8'hFF; CMD_DATA = 8'hEE; CMD_FUN = 4'hF; CMD_TYPE = 2'd0;
    for (int i = 0; i < 8; i++) begin
      TX_READY = (i % 2 == 1);
      vectors++; if (TX_VALID !== 1'b1 || TX_DATA !== exp[i/2]) begin miscompares++; $display("FAIL alu_tx%0d got %b/%h exp 1/%h", i, TX_VALID, TX_DATA, exp[i/2]); end
      step;
    end
    TX_READY = 1'b1;
    vectors++; if (TX_VALID !== 1'b0 || BUSY !== 1'b1) begin miscompares++; $display("FAIL alu_wait got txv=%b busy=%b exp 0/1", TX_VALID, BUSY); end
    RX_VALID = 1'b1; RX_DATA = 8'h34;
    step;
    RX_VALID = 1'b0;
    vectors++; if (RSP_VALID !== 1'b0 || RSP_DATA !== 16'h0034) begin miscompares++; $display("FAIL alu_lsb got %b/%h exp 0/0034", RSP_VALID, RSP_DATA); end
    step;
    RX_VALID = 1'b1; RX_DATA = 8'h12;
    step;
    vectors++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h1234) begin miscompares++; $display("FAIL alu_rsp got %b/%h exp 1/1234", RSP_VALID, RSP_DATA); end
    RX_DATA = 8'h99;
    step;
    RX_VALID = 1'b0;
    vectors++; if (RSP_DATA !== 16'h1234 || RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL alu_extra got %b/%h exp 0/1234", RSP_VALID, RSP_DATA); end
  endtask

  task automatic test_timeout;
    logic [7:0] exp [2];
    exp = '{8'hDD, 8'h02};
    CMD_TYPE = 2'd3; CMD_ADDR = 8'h00; CMD_DATA = 8'h00; CMD_FUN = 4'h2; TX_READY = 1'b1;
    CMD_VALID = 1'b1;
    step;
    CMD_VALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin miscompares++; $display("FAIL to_tx%0d got %b/%h exp 1/%h", i, TX_VALID, TX_DATA, exp[i]); end
      step;
    end
    for (int c = 0; c < 16; c++) begin
      vectors++; if (RSP_TIMEOUT !== 1'b0 || RSP_VALID !== 1'b0 || BUSY !== 1'b1) begin miscompares++; $display("FAIL to_wait%0d got to=%b v=%b busy=%b exp 0/0/1", c, RSP_TIMEOUT, RSP_VALID, BUSY); end
      step;
    end
    vectors++; if (RSP_TIMEOUT !== 1'b1 || CMD_READY !== 1'b1 || RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL to_pulse got to=%b rdy=%b v=%b exp 1/1/0", RSP_TIMEOUT, CMD_READY, RSP_VALID); end
    vectors++; if (RSP_DATA !== 16'h0000) begin miscompares++; $display("FAIL to_data got %h exp 0000", RSP_DATA); end
    step;
    vectors++; if (RSP_TIMEOUT !== 1'b0 || RSP_VALID !== 1'b0) begin miscompares++; $display("FAIL to_after got to=%b v=%b exp 0/0", RSP_TIMEOUT, RSP_VALID); end
  endtask

  task automatic test_byte_wins;
    CMD_TYPE = 2'd3; CMD_FUN = 4'h2; TX_READY = 1'b1;
    CMD_VALID = 1'b1;
    step;
    CMD_VALID = 1'b0;
    step;
    step;
    for (int c = 0; c < 15; c++) begin
      vectors++; if (RSP_TIMEOUT !== 1'b0 || BUSY !== 1'b1) begin miscompares++; $display("FAIL bw_wait%0d got to=%b busy=%b exp 0/1", c, RSP_TIMEOUT, BUSY); end
      step;
    end
    RX_VALID = 1'b1; RX_DATA = 8'h77;
    step;
    RX_VALID = 1'b0;
    vectors++; if (RSP_TIMEOUT !== 1'b0 || BUSY !== 1'b1 || RSP_DATA !== 16'h0077) begin miscompares++; $display("FAIL bw_keep got to=%b busy=%b d=%h exp 0/1/0077", RSP_TIMEOUT, BUSY, RSP_DATA); end
    RX_VALID = 1'b1; RX_DATA = 8'h00;
    step;
    RX_VALID = 1'b0;
    vectors++; if (RSP_VALID !== 1'b1 || RSP_TIMEOUT !== 1'b0 || RSP_DATA !== 16'h0077) begin miscompares++; $display("FAIL bw_rsp got v=%b to=%b d=%h exp 1/0/0077", RSP_VALID, RSP_TIMEOUT, RSP_DATA); end
    step;
  endtask

  task automatic test_back_to_back;
    CMD_TYPE = 2'd2; CMD_ADDR = 8'h11; CMD_DATA = 8'h22; CMD_FUN = 4'h5; TX_READY = 1'b0;
    CMD_VALID = 1'b1;
    step;
    CMD_VALID = 1'b0;
    TX_READY = 1'b1;
    vectors++; if (TX_DATA !== 8'hCC) begin miscompares++; $display("FAIL ab_tx0 got %h exp CC", TX_DATA); end
    step;
    vectors++; if (TX_DATA !== 8'h11) begin miscompares++; $display("FAIL ab_tx1 got %h exp 11", TX_DATA); end
    RST = 1'b1;
    #1;
    vectors++; if (TX_VALID !== 1'b0 || TX_DATA !== 8'h00 || BUSY !== 1'b0 || CMD_READY !== 1'b1) begin miscompares++; $display("FAIL ab_rst got txv=%b txd=%h busy=%b rdy=%b exp 0/00/0/1", TX_VALID, TX_DATA, BUSY, CMD_READY); end
    vectors++; if (RSP_VALID !== 1'b0 || RSP_TIMEOUT !== 1'b0 || RSP_DATA !== 16'h0000) begin miscompares++; $display("FAIL ab_rst_rsp got v=%b to=%b d=%h exp 0/0/0000", RSP_VALID, RSP_TIMEOUT, RSP_DATA); end
    step;
    RST = 1'b0;
    step;
    RX_VALID = 1'b1; RX_DATA = 8'h55;
    step;
    step;
    RX_VALID = 1'b0;
    vectors++; if (BUSY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_DATA !== 16'h0000) begin miscompares++; $display("FAIL ab_rxidle got busy=%b v=%b d=%h exp 0/0/0000", BUSY, RSP_VALID, RSP_DATA); end
    CMD_TYPE = 2'd1; CMD_ADDR = 8'h07; CMD_DATA = 8'h00; CMD_FUN = 4'h0;
    CMD_VALID = 1'b1;
    step;
    CMD_TYPE = 2'd3; CMD_ADDR = 8'h99; CMD_FUN = 4'hA;
    vectors++; if (CMD_READY !== 1'b0 || TX_DATA !== 8'hBB) begin miscompares++; $display("FAIL ab_busy0 got rdy=%b txd=%h exp 0/BB", CMD_READY, TX_DATA); end
    step;
    vectors++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h07) begin miscompares++; $display("FAIL ab_busy1 got %b/%h exp 1/07", TX_VALID, TX_DATA); end
    CMD_VALID = 1'b0;
    step;
    vectors++; if (TX_VALID !== 1'b0 || BUSY !== 1'b1) begin miscompares++; $display("FAIL ab_wait got txv=%b busy=%b exp 0/1", TX_VALID, BUSY); end
    RX_VALID = 1'b1; RX_DATA = 8'hC3;
    step;
    RX_VALID = 1'b0;
    vectors++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h00C3) begin miscompares++; $display("FAIL ab_rsp got %b/%h exp 1/00C3", RSP_VALID, RSP_DATA); end
    step;
    vectors++; if (CMD_READY !== 1'b1 || TX_VALID !== 1'b0) begin miscompares++; $display("FAIL ab_end got rdy=%b txv=%b exp 1/0", CMD_READY, TX_VALID); end
  endtask

  initial begin
    test_reset;
    test_rf_rd;
    test_rf_wr;
    test_alu_op;
    test_timeout;
    test_byte_wins;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
